// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_t          : reader FSM encoding (2 bits)
//   TAG_W            : number of tag bits carried beside each data beat
//   TAG_SOP, TAG_EOP : tag bit positions, stored as {sop, eop}
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int TAG_W   = 2;
    localparam int TAG_SOP = 1;
    localparam int TAG_EOP = 0;

endpackage

// File: rtl/stream_skid_2.sv
// Two-entry valid/ready FIFO buffer.
// Ports:
//   i_clk, i_rst       clock, async active-high reset
//   i_valid, i_data    write side; the producer only pushes when a slot is free
//   o_valid, o_data    head entry, held stable until popped
//   i_ready            consumer ready; pop = o_valid & i_ready
//   o_occ              number of stored entries (0..2)
module stream_skid_2 #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_occ;
    logic         w_pop;

    assign w_pop   = (r_occ != 2'd0) & i_ready;
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_head;
    assign o_occ   = r_occ;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_valid, w_pop})
                2'b10: begin
                    // a push into a full buffer is dropped; the reader never issues one
                    if (r_occ == 2'd0) begin
                        r_head <= i_data;
                        r_occ  <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_tail <= i_data;
                        r_occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side consumer of the async FIFO: converts empty/almost-empty flags into
// fixed-length SOP/EOP bursts on a valid/ready stream, with a timeout flush for
// data stuck below the burst threshold.
// Ports:
//   i_clk, i_rst                       clock, async active-high reset
//   i_fifo_empty, i_fifo_almost_empty  FIFO flags
//   i_fifo_wr_en                       FIFO write; blocks a read in the same cycle
//   i_fifo_rd_data                     FIFO registered read data (valid 1 cycle after accept)
//   o_fifo_rd_en                       FIFO read request
//   o_data, o_valid, i_ready           output stream
//   o_sop, o_eop                       first / last beat of a burst
//   o_busy                             FSM not idle
//
// state    | meaning
// ST_IDLE  | waiting for a full burst or for the timeout to expire
// ST_BURST | issuing BURST_LEN reads, stalls (no EOP) if the FIFO empties
// ST_FLUSH | issuing one sop+eop read for data below the burst threshold
// ST_DRAIN | all reads issued, waiting for the last beat to leave the skid
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_almost_empty,
    input  logic             i_fifo_wr_en,
    input  logic [WIDTH-1:0] i_fifo_rd_data,
    output logic             o_fifo_rd_en,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sop,
    output logic             o_eop,
    output logic             o_busy
);

    localparam int ISS_W = $clog2(BURST_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ISS_W-1:0] ISS_FULL = ISS_W'(BURST_LEN);
    localparam logic [ISS_W-1:0] ISS_LAST = ISS_W'(BURST_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ISS_W-1:0]       r_issued;
    logic [ISS_W-1:0]       w_issued_nxt;
    logic [TMO_W-1:0]       r_tmo;
    logic [TMO_W-1:0]       w_tmo_nxt;
    logic                   r_inflight;
    logic [TAG_W-1:0]       r_if_tag;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_want;
    logic                   w_room;
    logic                   w_acc;
    logic                   w_pop;
    logic [1:0]             w_occ;
    logic                   w_skid_valid;
    logic [WIDTH+TAG_W-1:0] w_skid_data;

    assign w_pop = w_skid_valid & i_ready;

    // Slots committed after this edge: stored + in flight - leaving. Pop implies
    // occ >= 1, so the subtraction never underflows.
    assign w_room = (({1'b0, w_occ} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;

    assign w_want = ((r_state == ST_BURST) && (r_issued < ISS_FULL))
                  | ((r_state == ST_FLUSH) && (r_issued == '0));

    assign o_fifo_rd_en = w_want & ~i_fifo_empty & w_room;
    assign w_acc        = o_fifo_rd_en & ~i_fifo_wr_en;

    assign w_tag[TAG_SOP] = (r_issued == '0);
    assign w_tag[TAG_EOP] = (r_state == ST_FLUSH) | (r_issued == ISS_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_issued_nxt = r_issued;
        w_tmo_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (!i_fifo_almost_empty) begin
                    w_state_nxt  = ST_BURST;
                    w_issued_nxt = '0;
                end else if ((r_tmo == TMO_MAX) && !i_fifo_empty) begin
                    w_state_nxt  = ST_FLUSH;
                    w_issued_nxt = '0;
                end else if (!i_fifo_empty) begin
                    // below TMO_MAX here, so the count cannot pass TIMEOUT
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_BURST: begin
                if (w_acc) begin
                    w_issued_nxt = r_issued + ISS_W'(1);
                    if (r_issued == ISS_LAST) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_acc) begin
                    w_issued_nxt = r_issued + ISS_W'(1);
                    w_state_nxt  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((w_occ == 2'd0) && !r_inflight) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_issued   <= '0;
            r_tmo      <= '0;
            r_inflight <= 1'b0;
            r_if_tag   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_issued   <= w_issued_nxt;
            r_tmo      <= w_tmo_nxt;
            r_inflight <= w_acc;
            if (w_acc) begin
                r_if_tag <= w_tag;
            end
        end
    end

    // The FIFO's read data is valid the cycle after accept; capture it with its tags then.
    stream_skid_2 #(
        .W (WIDTH + TAG_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (r_inflight),
        .i_data  ({r_if_tag, i_fifo_rd_data}),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .i_ready (i_ready),
        .o_occ   (w_occ)
    );

    assign o_valid = w_skid_valid;
    assign o_data  = w_skid_data[WIDTH-1:0];
    assign o_sop   = w_skid_valid & w_skid_data[WIDTH+TAG_SOP];
    assign o_eop   = w_skid_valid & w_skid_data[WIDTH+TAG_EOP];
    assign o_busy  = (r_state != ST_IDLE);

endmodule
